// File: rtl/sram_sp_be_ctrl.sv
// sram_sp_be_ctrl: initiator-side controller for a single-port SRAM with
// per-column write enables. Round-robin arbitration between independent
// write and read request streams; read data returns through a
// credit-protected response FIFO.
`timescale 1ns/1ps

module sram_sp_be_ctrl #(
    parameter int SIZE      = 256,
    parameter int SIZE_COL  = 8,
    parameter int DATA_WD   = 32,
    parameter int RSP_DEPTH = 4,
    localparam int SIZE_WD  = $clog2(SIZE),
    localparam int COL_NUM  = DATA_WD / SIZE_COL,
    localparam int PTR_WD   = $clog2(RSP_DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_req_val_i,
    output logic               wr_req_rdy_o,
    input  logic [SIZE_WD-1:0] wr_req_adr_i,
    input  logic [COL_NUM-1:0] wr_req_msk_i,
    input  logic [DATA_WD-1:0] wr_req_dat_i,
    input  logic               rd_req_val_i,
    output logic               rd_req_rdy_o,
    input  logic [SIZE_WD-1:0] rd_req_adr_i,
    output logic               rd_rsp_val_o,
    input  logic               rd_rsp_rdy_i,
    output logic [DATA_WD-1:0] rd_rsp_dat_o,
    output logic [SIZE_WD-1:0] sram_adr_o,
    output logic [COL_NUM-1:0] sram_wr_val_o,
    output logic [DATA_WD-1:0] sram_wr_dat_o,
    output logic               sram_rd_val_o,
    input  logic [DATA_WD-1:0] sram_rd_dat_i
);

    // Arbitration priority: 0 favours read, 1 favours write.
    logic               pri;
    // Set for the cycle in which SRAM read data is on sram_rd_dat_i.
    logic               inflight;

    logic [DATA_WD-1:0] fifo_mem [RSP_DEPTH];
    logic [PTR_WD-1:0]  wr_ptr;
    logic [PTR_WD-1:0]  rd_ptr;
    logic [PTR_WD:0]    occ;

    logic [PTR_WD+1:0]  cnt;
    logic               rd_ok;
    logic               rd_grant;
    logic               wr_grant;
    logic               push;
    logic               pop;

    // Credit check, handshake readiness and grants; readies are held low in reset.
    always_comb begin
        cnt          = {1'b0, occ} + {{(PTR_WD+1){1'b0}}, inflight};
        rd_ok        = (cnt < (PTR_WD+2)'(RSP_DEPTH));
        rd_req_rdy_o = rst_n & rd_ok & (~wr_req_val_i | ~pri);
        wr_req_rdy_o = rst_n & (~rd_req_val_i | ~rd_ok | pri);
        rd_grant     = rd_req_val_i & rd_req_rdy_o;
        wr_grant     = wr_req_val_i & wr_req_rdy_o;
        push         = inflight;
        pop          = (occ != '0) & rd_rsp_rdy_i;
    end

    // SRAM port drive in the same cycle as the grant.
    always_comb begin
        sram_rd_val_o = rd_grant;
        sram_wr_val_o = wr_grant ? wr_req_msk_i : '0;
        sram_adr_o    = rd_grant ? rd_req_adr_i : wr_req_adr_i;
        sram_wr_dat_o = wr_req_dat_i;
    end

    assign rd_rsp_val_o = (occ != '0);
    assign rd_rsp_dat_o = fifo_mem[rd_ptr];

    // Priority, in-flight tracking and response FIFO state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pri      <= 1'b0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (rd_grant) begin
                pri <= 1'b1;
            end else if (wr_grant) begin
                pri <= 1'b0;
            end

            inflight <= rd_grant;

            if (push) begin
                assert (occ != (PTR_WD+1)'(RSP_DEPTH))
                    else $fatal(1, "sram_sp_be_ctrl: response FIFO push while full");
                fifo_mem[wr_ptr] <= sram_rd_dat_i;
                wr_ptr           <= wr_ptr + 1'b1;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (push && !pop) begin
                occ <= occ + 1'b1;
            end else if (pop && !push) begin
                occ <= occ - 1'b1;
            end
        end
    end

endmodule
